// File: rtl/cmp_pkg.sv
// Shared types and constants for the compare stream tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_pkg;

  // Tracker FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit positions of the less / equal / greater flags in a result vector.
  localparam int LT = 0;
  localparam int EQ = 1;
  localparam int GT = 2;

  // Default build parameters.
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_FRAME_LEN = 8;

endpackage

// File: rtl/cmp_core.sv
// Unsigned magnitude comparator producing one-hot less/equal/greater flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module cmp_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             l,
  output logic             e,
  output logic             h
);

  assign l = (a <  b);
  assign e = (a == b);
  assign h = (a >  b);

endmodule

// File: rtl/compare_stream_tracker.sv
// Frame-based consumer of operand pairs: registers per-pair compare results, tallies outcomes, tracks max operand.
// Latency: result registered one cycle after accept; done pulses in the same cycle as the last pair's result.
// Backpressure: in_ready high only while accumulating; frame stops accepting on the edge of its last pair.
module compare_stream_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_gt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [WIDTH-1:0] max_seen,
  output logic             busy,
  output logic             done
);

  // Sample counter is sized from FRAME_LEN so it never limits the frame length.
  localparam int               SMP_W    = $clog2(FRAME_LEN + 1);
  localparam logic [SMP_W-1:0] LAST_IDX = SMP_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [SMP_W-1:0] smp_cnt;
  logic [2:0]       res;
  logic             cmp_l;
  logic             cmp_e;
  logic             cmp_h;
  logic             accept;
  logic             last_accept;
  logic [WIDTH-1:0] pair_max;

  cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a (a),
    .b (b),
    .l (cmp_l),
    .e (cmp_e),
    .h (cmp_h)
  );

  assign in_ready    = (state == ACCUM);
  assign busy        = (state == ACCUM);
  assign done        = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (smp_cnt == LAST_IDX);
  // The comparator already knows which operand is larger; reuse it.
  assign pair_max    = cmp_h ? a : b;

  assign res_lt = res[LT];
  assign res_eq = res[EQ];
  assign res_gt = res[GT];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only counts in IDLE, DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last_accept) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result valid strobe: high exactly in the cycle after an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= accept;
    end
  end

  // Frame datapath: clear on start from IDLE, update result, tallies and max on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res      <= '0;
      lt_cnt   <= '0;
      eq_cnt   <= '0;
      gt_cnt   <= '0;
      max_seen <= '0;
      smp_cnt  <= '0;
    end else if (state == IDLE && start) begin
      lt_cnt   <= '0;
      eq_cnt   <= '0;
      gt_cnt   <= '0;
      max_seen <= '0;
      smp_cnt  <= '0;
    end else if (accept) begin
      res[LT] <= cmp_l;
      res[EQ] <= cmp_e;
      res[GT] <= cmp_h;
      if (cmp_l && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_W'(1);
      if (cmp_e && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_W'(1);
      if (cmp_h && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_W'(1);
      if (pair_max > max_seen) max_seen <= pair_max;
      smp_cnt <= smp_cnt + SMP_W'(1);
    end
  end

endmodule

// File: tb/tb_compare_stream_tracker.sv
// Self-checking bench for compare_stream_tracker: vector table, random frames vs reference model, corner sequences.
// Latency: checks sample outputs 1ns after each rising edge.
// Backpressure: drives in_valid with optional idle gaps; a second small instance exercises counter saturation.
module tb_compare_stream_tracker;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_ready;
  logic        res_valid;
  logic        res_lt;
  logic        res_eq;
  logic        res_gt;
  logic [15:0] lt_cnt;
  logic [15:0] eq_cnt;
  logic [15:0] gt_cnt;
  logic [31:0] max_seen;
  logic        busy;
  logic        done;

  // Small instance for saturation: 2-bit counters, frame longer than the counter range.
  logic       s_start;
  logic       s_valid;
  logic [7:0] s_a;
  logic [7:0] s_b;
  logic       s_ready;
  logic       s_res_valid;
  logic       s_lt;
  logic       s_eq;
  logic       s_gt;
  logic [1:0] s_lt_cnt;
  logic [1:0] s_eq_cnt;
  logic [1:0] s_gt_cnt;
  logic [7:0] s_max;
  logic       s_busy;
  logic       s_done;

  always #5 clk = ~clk;

  compare_stream_tracker #(.WIDTH(32), .CNT_W(16), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .res_valid(res_valid), .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
    .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .max_seen(max_seen),
    .busy(busy), .done(done)
  );

  compare_stream_tracker #(.WIDTH(8), .CNT_W(2), .FRAME_LEN(5)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .a(s_a), .b(s_b), .res_valid(s_res_valid), .res_lt(s_lt), .res_eq(s_eq), .res_gt(s_gt),
    .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt), .gt_cnt(s_gt_cnt), .max_seen(s_max),
    .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  e;   // expected {gt, eq, lt}
  } vec_t;

  vec_t        tab[8];
  logic [31:0] fa[FL];
  logic [31:0] fb[FL];
  logic [2:0]  fe[FL];

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show right now.
  int          m_lt;
  int          m_eq;
  int          m_gt;
  logic [31:0] m_max;
  logic [2:0]  m_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y);
    if (x < y)       return 3'b001;
    else if (x == y) return 3'b010;
    else             return 3'b100;
  endfunction

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_lt = 0; m_eq = 0; m_gt = 0; m_max = '0;
  endtask

  task automatic model_accept(input logic [31:0] x, input logic [31:0] y);
    m_res = ref_cmp(x, y);
    if (m_res == 3'b001) m_lt = sat16(m_lt);
    if (m_res == 3'b010) m_eq = sat16(m_eq);
    if (m_res == 3'b100) m_gt = sat16(m_gt);
    if (x > m_max) m_max = x;
    if (y > m_max) m_max = y;
  endtask

  task automatic check_outputs(input string tag, input logic e_rv, input logic e_done, input logic e_busy);
    chk({tag, " res_valid"}, res_valid, e_rv);
    chk({tag, " res"}, {res_gt, res_eq, res_lt}, m_res);
    chk({tag, " lt_cnt"}, lt_cnt, m_lt);
    chk({tag, " eq_cnt"}, eq_cnt, m_eq);
    chk({tag, " gt_cnt"}, gt_cnt, m_gt);
    chk({tag, " max_seen"}, max_seen, m_max);
    chk({tag, " done"}, done, e_done);
    chk({tag, " busy"}, busy, e_busy);
    chk({tag, " in_ready"}, in_ready, e_busy);
  endtask

  // Runs one frame from IDLE using fa/fb/fe; entered and left 1ns after a rising edge.
  task automatic run_frame(input string tag, input int gap, input logic hold_start);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    model_clear();
    check_outputs({tag, " start"}, 1'b0, 1'b0, 1'b1);
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      a = fa[i]; b = fb[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      model_accept(fa[i], fb[i]);
      chk({tag, " vec res"}, {res_gt, res_eq, res_lt}, fe[i]);
      check_outputs({tag, " acc"}, 1'b1, (i == FL - 1), (i != FL - 1));
      if (i != FL - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check_outputs({tag, " gap"}, 1'b0, 1'b0, 1'b1);
        end
      end
    end
    @(posedge clk); #1;
    check_outputs({tag, " post"}, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
  endtask

  task automatic load_tab(input int base);
    for (int i = 0; i < FL; i++) begin
      fa[i] = tab[base + i].a;
      fb[i] = tab[base + i].b;
      fe[i] = tab[base + i].e;
    end
  endtask

  initial begin
    tab[0] = '{32'd22,         32'd200,        3'b001};
    tab[1] = '{32'd233,        32'd200,        3'b100};
    tab[2] = '{32'd888,        32'd888,        3'b010};
    tab[3] = '{32'd123,        32'd234,        3'b001};
    tab[4] = '{32'h0,          32'hFFFF_FFFF,  3'b001};
    tab[5] = '{32'hFFFF_FFFF,  32'h0,          3'b100};
    tab[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b010};
    tab[7] = '{32'h0,          32'h0,          3'b010};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0;
    model_clear();
    m_res = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("idle", 1'b0, 1'b0, 1'b0);

    // Basic frame, back-to-back pairs.
    load_tab(0);
    run_frame("t1", 0, 1'b0);
    chk("t1 final lt_cnt", lt_cnt, 2);
    chk("t1 final eq_cnt", eq_cnt, 1);
    chk("t1 final gt_cnt", gt_cnt, 1);
    chk("t1 final max", max_seen, 888);

    // Same frame with two idle cycles between pairs.
    run_frame("t2", 2, 1'b0);
    chk("t2 final lt_cnt", lt_cnt, 2);
    chk("t2 final eq_cnt", eq_cnt, 1);
    chk("t2 final gt_cnt", gt_cnt, 1);

    // Extreme operand values.
    load_tab(4);
    run_frame("t4", 0, 1'b0);
    chk("t4 final lt_cnt", lt_cnt, 1);
    chk("t4 final eq_cnt", eq_cnt, 2);
    chk("t4 final gt_cnt", gt_cnt, 1);
    chk("t4 final max", max_seen, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a frame.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'd1; b = 32'd2; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t3 mid busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    m_res = 3'b000;
    check_outputs("t3 async rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < FL; i++) begin
      fa[i] = 32'd5; fb[i] = 32'd5; fe[i] = 3'b010;
    end
    run_frame("t3", 0, 1'b0);
    chk("t3 final eq_cnt", eq_cnt, 4);
    chk("t3 final lt_cnt", lt_cnt, 0);
    chk("t3 final gt_cnt", gt_cnt, 0);
    chk("t3 final max", max_seen, 5);

    // start held through the frame and DONE: no restart, results held in IDLE.
    load_tab(0);
    run_frame("t5", 1, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check_outputs("t5 hold", 1'b0, 1'b0, 1'b0);
    end

    // Random frames against the reference model.
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < FL; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          fa[i] = $urandom_range(0, 3);
          fb[i] = $urandom_range(0, 3);
        end else begin
          fa[i] = $urandom;
          fb[i] = $urandom;
        end
        fe[i] = ref_cmp(fa[i], fb[i]);
      end
      run_frame("rnd", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check_outputs("rnd idle", 1'b0, 1'b0, 1'b0);
      end
    end

    // Saturation: 5 less-than pairs into 2-bit counters stop at 3.
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("sat busy", s_busy, 1'b1);
    s_a = 8'd1; s_b = 8'd2; s_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("sat lt_cnt", s_lt_cnt, (k < 3) ? k : 3);
      chk("sat res_lt", s_lt, 1'b1);
      chk("sat done", s_done, (k == 5));
      chk("sat in_ready", s_ready, (k != 5));
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("sat hold lt_cnt", s_lt_cnt, 2'd3);
    chk("sat eq_cnt", s_eq_cnt, 2'd0);
    chk("sat max", s_max, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
